vga_reg_bank: RTL



---
 rtl/vga_reg_bank_pkg.sv | 31 +++
 rtl/reg_change_tracker.sv | 49 ++++
 rtl/vga_reg_bank.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_reg_bank_pkg.sv
// Shared constants and helpers for the VGA register-bank text overlay.
//   - 3-bit RGB colour codes used by the text/font stage
//   - hex_digits(): number of hex characters needed for a w-bit value
//   - idx_bits():   index width for an n-entry table (minimum 1 bit)
package vga_reg_bank_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int unsigned FONT_WIDTH = 8;
  // Hold counters are a fixed 8 bits wide.
  localparam int unsigned CNT_W      = 8;

  function automatic int unsigned hex_digits(input int unsigned w);
    return (w + 3) / 4;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned n);
    int unsigned b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/reg_change_tracker.sv
// Per-register frame snapshot plus change-highlight hold counter.
//   px_clk, rst  : pixel clock, synchronous active-high reset
//   frame_tick   : one-cycle end-of-frame pulse; snapshot and counter update here
//   din          : live register value
//   snapshot     : value latched at the last frame_tick
//   hilite       : 1 while the hold counter is non-zero
module reg_change_tracker
  import vga_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic             px_clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] snapshot,
  output logic             hilite
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Reload on change beats decrement; the counter saturates at zero.
  always_comb begin
    cnt_next = cnt;
    if (frame_tick) begin
      if ((HOLD_FRAMES != 0) && (din != snapshot)) begin
        cnt_next = CNT_W'(HOLD_FRAMES);
      end else if (cnt != '0) begin
        cnt_next = cnt - CNT_W'(1);
      end
    end
  end

  // hilite is registered from cnt_next so it always equals (cnt != 0).
  always_ff @(posedge px_clk) begin
    if (rst) begin
      snapshot <= '0;
      cnt      <= '0;
      hilite   <= 1'b0;
    end else begin
      if (frame_tick) snapshot <= din;
      cnt    <= cnt_next;
      hilite <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/vga_reg_bank.sv
// Displays NUM_REGS registers as hex text, one register per text row,
// with change highlighting. Outputs follow the OR-bus convention (all
// zero outside the region) and lag x/y by two px_clk cycles.
//   px_clk, rst      : pixel clock, synchronous active-high reset
//   x, y             : current pixel coordinates
//   en               : block enable
//   frame_tick       : end-of-frame pulse; registers are sampled here
//   din              : flattened registers, reg i = din[i*WIDTH +: WIDTH]
//   dout, h2a        : {4'b0, nibble} and its valid flag for hex2asc
//   color, zoom      : digit colour and zoom exponent
module vga_reg_bank
  import vga_reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned line        = 0,
  parameter int unsigned col         = 0,
  parameter int unsigned pzoom       = 0,
  parameter logic [2:0]  pcolor      = YELLOW,
  parameter logic [2:0]  HI_COLOR    = RED,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic                      px_clk,
  input  logic                      rst,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      en,
  input  logic                      frame_tick,
  input  logic [NUM_REGS*WIDTH-1:0] din,
  output logic [7:0]                dout,
  output logic                      h2a,
  output logic [2:0]                color,
  output logic [1:0]                zoom
);

  localparam int unsigned DIGITS = hex_digits(WIDTH);
  localparam int unsigned PADW   = DIGITS * 4;
  localparam int unsigned RW     = idx_bits(NUM_REGS);
  localparam int unsigned DW     = idx_bits(DIGITS);
  // Tables are padded to a power of two so every index value is in range.
  localparam int unsigned NR_P   = 1 << RW;
  localparam int unsigned DG_P   = 1 << DW;
  localparam int unsigned SHIFT  = 3 + pzoom;

  logic [3:0]      nib [NR_P][DG_P];
  logic [NR_P-1:0] hilite;

  // One tracker per register; unused table slots read zero.
  for (genvar i = 0; i < NR_P; i++) begin : g_reg
    if (i < NUM_REGS) begin : g_live
      logic [WIDTH-1:0] snap;
      logic [PADW-1:0]  pad;
      logic             hl;

      reg_change_tracker #(
        .WIDTH       (WIDTH),
        .HOLD_FRAMES (HOLD_FRAMES)
      ) u_trk (
        .px_clk     (px_clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .din        (din[i*WIDTH +: WIDTH]),
        .snapshot   (snap),
        .hilite     (hl)
      );

      // Missing high bits of the top digit read as zero.
      assign pad       = PADW'(snap);
      assign hilite[i] = hl;
      for (genvar j = 0; j < DG_P; j++) begin : g_dig
        if (j < DIGITS) begin : g_used
          assign nib[i][j] = pad[4*j +: 4];
        end else begin : g_unused
          assign nib[i][j] = 4'h0;
        end
      end
    end else begin : g_pad
      assign hilite[i] = 1'b0;
      for (genvar j = 0; j < DG_P; j++) begin : g_dig
        assign nib[i][j] = 4'h0;
      end
    end
  end

  // Region decode in character-cell coordinates.
  logic [9:0] cx, cy, rel_x, rel_y;
  logic       active_c;

  always_comb begin
    cx       = x >> SHIFT;
    cy       = y >> SHIFT;
    rel_x    = cx - 10'(col);
    rel_y    = cy - 10'(line);
    active_c = en
             && (cy >= 10'(line)) && (rel_y < 10'(NUM_REGS))
             && (cx >= 10'(col))  && (rel_x < 10'(DIGITS));
  end

  // Stage A: cell position; leftmost cell is the most significant digit.
  logic          act_a;
  logic [RW-1:0] r_a;
  logic [DW-1:0] d_a;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      act_a <= 1'b0;
      r_a   <= '0;
      d_a   <= '0;
    end else begin
      act_a <= active_c;
      r_a   <= RW'(rel_y);
      d_a   <= DW'(DIGITS - 1) - DW'(rel_x);
    end
  end

  // Stage B: nibble lookup and colour; all-zero when inactive.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      dout  <= '0;
      h2a   <= 1'b0;
      color <= '0;
      zoom  <= '0;
    end else if (act_a) begin
      dout  <= {4'b0, nib[r_a][d_a]};
      h2a   <= 1'b1;
      color <= hilite[r_a] ? HI_COLOR : pcolor;
      zoom  <= 2'(pzoom);
    end else begin
      dout  <= '0;
      h2a   <= 1'b0;
      color <= '0;
      zoom  <= '0;
    end
  end

endmodule
